// File: rtl/mccu_quota_supervisor_if.sv
// Bundles the MCCU-facing quota signals and the software-facing status/control
// of the quota supervisor.
interface mccu_quota_supervisor_if #(
  parameter int N_CORES    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                                 enable_i;
  logic [N_CORES-1:0]                   irq_quota_i;
  logic [N_CORES-1:0][DATA_WIDTH-1:0]   quota_i;
  logic [N_CORES-1:0]                   irq_mask_i;
  logic [N_CORES-1:0]                   reload_en_i;
  logic [N_CORES-1:0]                   clear_i;
  logic [N_CORES-1:0]                   status_o;
  logic                                 irq_o;
  logic [N_CORES-1:0]                   update_quota_o;
  logic [N_CORES-1:0][CNT_WIDTH-1:0]    overrun_cnt_o;
  logic [N_CORES-1:0][CNT_WIDTH-1:0]    exhaust_cnt_o;

  modport master (
    output enable_i, irq_quota_i, quota_i, irq_mask_i, reload_en_i, clear_i,
    input  status_o, irq_o, update_quota_o, overrun_cnt_o, exhaust_cnt_o
  );
  modport slave (
    input  enable_i, irq_quota_i, quota_i, irq_mask_i, reload_en_i, clear_i,
    output status_o, irq_o, update_quota_o, overrun_cnt_o, exhaust_cnt_o
  );
endinterface

// File: rtl/mccu_quota_supervisor.sv
// Quota supervisor: per-core sticky exhaustion status, overrun/episode counters,
// optional quota re-arm pulse, and one maskable combined interrupt.
module mccu_qs_core #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  enable_i,
  input  logic                  irq_quota_i,
  input  logic [DATA_WIDTH-1:0] quota_i,
  input  logic                  reload_en_i,
  input  logic                  clear_i,
  output logic                  status_o,
  output logic                  update_quota_o,
  output logic [CNT_WIDTH-1:0]  overrun_cnt_o,
  output logic [CNT_WIDTH-1:0]  exhaust_cnt_o
);
  typedef enum logic [1:0] {IDLE, MONITOR, EXHAUSTED, RELOAD} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 status_q, status_d;
  logic [CNT_WIDTH-1:0] ovr_q, ovr_d, exc_q, exc_d;
  logic                 exh;

  assign exh = enable_i && (irq_quota_i || quota_i == '0);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    ovr_d    = ovr_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (clear_i)  status_d = 1'b0;
        if (enable_i) state_d  = MONITOR;
      end
      MONITOR: begin
        if (clear_i) status_d = 1'b0;
        if (!enable_i) begin
          state_d = IDLE;
        end else if (exh) begin
          // exhaustion outranks a same-cycle acknowledge
          state_d  = EXHAUSTED;
          status_d = 1'b1;
          ovr_d    = '0;
          if (exc_q != CNT_MAX) exc_d = exc_q + CNT_ONE;
        end
      end
      EXHAUSTED: begin
        if (clear_i) begin
          status_d = 1'b0;
          state_d  = reload_en_i ? RELOAD : MONITOR;
        end else if (!enable_i) begin
          state_d = IDLE;
        end else if (ovr_q != CNT_MAX) begin
          ovr_d = ovr_q + CNT_ONE;
        end
      end
      RELOAD: state_d = enable_i ? MONITOR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      status_q <= 1'b0;
      ovr_q    <= '0;
      exc_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      ovr_q    <= ovr_d;
      exc_q    <= exc_d;
    end
  end

  // Moore output: async reset kills an in-flight pulse immediately
  assign update_quota_o = (state_q == RELOAD);
  assign status_o       = status_q;
  assign overrun_cnt_o  = ovr_q;
  assign exhaust_cnt_o  = exc_q;
endmodule

module mccu_quota_supervisor #(
  parameter int N_CORES    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  mccu_quota_supervisor_if.slave  bus
);
  logic [N_CORES-1:0]                status, update;
  logic [N_CORES-1:0][CNT_WIDTH-1:0] ovr, exc;

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    mccu_qs_core #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_core (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .enable_i       (bus.enable_i),
      .irq_quota_i    (bus.irq_quota_i[g]),
      .quota_i        (bus.quota_i[g]),
      .reload_en_i    (bus.reload_en_i[g]),
      .clear_i        (bus.clear_i[g]),
      .status_o       (status[g]),
      .update_quota_o (update[g]),
      .overrun_cnt_o  (ovr[g]),
      .exhaust_cnt_o  (exc[g])
    );
  end

  assign bus.status_o       = status;
  assign bus.update_quota_o = update;
  assign bus.overrun_cnt_o  = ovr;
  assign bus.exhaust_cnt_o  = exc;
  // mask gates only the line, never the sticky status
  assign bus.irq_o          = |(status & ~bus.irq_mask_i);
endmodule

// File: tb/tb_mccu_quota_supervisor.sv
// Directed bench for mccu_quota_supervisor with a scoreboard queue of expectations.
module tb_mccu_quota_supervisor;
  localparam int NC = 4, DW = 32, CW = 8;
  localparam logic [63:0] MAXC = 64'((1 << CW) - 1);

  logic clk_i = 1'b0;
  logic rstn_i;
  always #5 clk_i = ~clk_i;

  mccu_quota_supervisor_if #(.N_CORES(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  mccu_quota_supervisor #(.N_CORES(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  typedef struct {string tag; logic [63:0] v;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty obs=%0h exp=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.v);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0;
    bus.enable_i = 1'b0; bus.irq_quota_i = '0; bus.irq_mask_i = '0;
    bus.reload_en_i = '0; bus.clear_i = '0;
    for (int c = 0; c < NC; c++) bus.quota_i[c] = 32'd100;
    step(2);
    push("rst_status", 0);  chk(64'(bus.status_o));
    push("rst_irq", 0);     chk(64'(bus.irq_o));
    push("rst_update", 0);  chk(64'(bus.update_quota_o));
    push("rst_ovr", 0);     chk(64'(bus.overrun_cnt_o));
    push("rst_exc", 0);     chk(64'(bus.exhaust_cnt_o));

    // quiet monitoring
    rstn_i = 1'b1; bus.enable_i = 1'b1;
    push("idle_status", 0); push("idle_irq", 0); push("idle_exc", 0);
    step(10);
    chk(64'(bus.status_o)); chk(64'(bus.irq_o)); chk(64'(bus.exhaust_cnt_o));

    // core1 exhaustion, overrun counting
    bus.irq_quota_i[1] = 1'b1;
    push("c1_status", 64'b0010); push("c1_irq", 1); push("c1_exc", 1); push("c1_ovr0", 0);
    step(); bus.irq_quota_i[1] = 1'b0;
    chk(64'(bus.status_o)); chk(64'(bus.irq_o));
    chk(64'(bus.exhaust_cnt_o[1])); chk(64'(bus.overrun_cnt_o[1]));
    push("c1_ovr4", 4);
    step(4);
    chk(64'(bus.overrun_cnt_o[1]));

    // core1 ack with reload
    bus.reload_en_i[1] = 1'b1; bus.clear_i[1] = 1'b1;
    push("c1_clr_status", 0); push("c1_upd", 64'b0010); push("c1_ovr_hold", 4);
    step(); bus.clear_i[1] = 1'b0;
    chk(64'(bus.status_o)); chk(64'(bus.update_quota_o)); chk(64'(bus.overrun_cnt_o[1]));
    push("c1_upd_end", 0);
    step(); chk(64'(bus.update_quota_o));
    push("c1_no_retrig", 0); push("c1_exc_hold", 1);
    step(2); chk(64'(bus.status_o)); chk(64'(bus.exhaust_cnt_o[1]));

    // core2 masked exhaustion
    bus.irq_mask_i[2] = 1'b1; bus.irq_quota_i[2] = 1'b1;
    push("c2_status", 64'b0100); push("c2_masked_irq", 0);
    step(); bus.irq_quota_i[2] = 1'b0;
    chk(64'(bus.status_o)); chk(64'(bus.irq_o));
    bus.irq_mask_i[2] = 1'b0;
    push("c2_unmask_irq", 1);
    #1 chk(64'(bus.irq_o));
    bus.clear_i[2] = 1'b1;
    push("c2_clr_status", 0); push("c2_clr_irq", 0); push("c2_no_upd", 0);
    step(); bus.clear_i[2] = 1'b0;
    chk(64'(bus.status_o)); chk(64'(bus.irq_o)); chk(64'(bus.update_quota_o));

    // MONITOR: exh and clear together -> exh wins
    bus.irq_quota_i[2] = 1'b1; bus.clear_i[2] = 1'b1;
    push("c2_exh_wins", 64'b0100); push("c2_exc2", 2);
    step(); chk(64'(bus.status_o)); chk(64'(bus.exhaust_cnt_o[2]));
    // EXHAUSTED: clear and exh together -> clear wins
    push("c2_clr_wins", 0); push("c2_exc_still2", 2);
    step(); bus.irq_quota_i[2] = 1'b0; bus.clear_i[2] = 1'b0;
    chk(64'(bus.status_o)); chk(64'(bus.exhaust_cnt_o[2]));

    // core0 overrun saturation
    bus.quota_i[0] = '0;
    step(); bus.quota_i[0] = 32'd100;
    push("c0_exc1", 1);
    chk(64'(bus.exhaust_cnt_o[0]));
    push("c0_ovr_sat", MAXC);
    step((1 << CW) + 5);
    chk(64'(bus.overrun_cnt_o[0]));

    // core0 episode saturation: clear/re-exhaust every 2 cycles
    bus.quota_i[0] = '0; bus.clear_i[0] = 1'b1;
    push("c0_exc_sat", MAXC); push("c0_ovr_reentry", 0); push("c0_status_set", 1);
    step(2 * ((1 << CW) + 4));
    chk(64'(bus.exhaust_cnt_o[0])); chk(64'(bus.overrun_cnt_o[0])); chk(64'(bus.status_o[0]));
    bus.quota_i[0] = 32'd100;
    push("c0_final_clr", 0);
    step(); bus.clear_i[0] = 1'b0;
    chk(64'(bus.status_o[0]));

    // core3 reload then enable drop
    bus.reload_en_i[3] = 1'b1; bus.irq_quota_i[3] = 1'b1;
    step(); bus.irq_quota_i[3] = 1'b0;
    bus.clear_i[3] = 1'b1;
    push("c3_upd", 64'b1000);
    step(); bus.clear_i[3] = 1'b0;
    chk(64'(bus.update_quota_o));
    bus.enable_i = 1'b0;
    push("c3_upd_held", 64'b1000);
    #1 chk(64'(bus.update_quota_o));
    push("c3_upd_done", 0);
    step(); chk(64'(bus.update_quota_o));
    // from IDLE, first enabled edge only reaches MONITOR
    bus.enable_i = 1'b1; bus.irq_quota_i[3] = 1'b1;
    push("c3_idle_first", 0);
    step(); chk(64'(bus.status_o[3]));
    push("c3_exh_second", 1);
    step(); bus.irq_quota_i[3] = 1'b0;
    chk(64'(bus.status_o[3]));

    // reset during RELOAD
    bus.clear_i[3] = 1'b1;
    push("c3_upd2", 64'b1000);
    step(); bus.clear_i[3] = 1'b0;
    chk(64'(bus.update_quota_o));
    rstn_i = 1'b0;
    push("rst2_upd", 0); push("rst2_status", 0); push("rst2_irq", 0);
    push("rst2_ovr", 0); push("rst2_exc", 0);
    #1;
    chk(64'(bus.update_quota_o)); chk(64'(bus.status_o)); chk(64'(bus.irq_o));
    chk(64'(bus.overrun_cnt_o)); chk(64'(bus.exhaust_cnt_o));
    push("rst2_upd_later", 0);
    step(); chk(64'(bus.update_quota_o));

    if (sb.size() != 0) begin
      total++; bad++;
      $error("FAIL sb_leftover obs=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
